// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Shared elevator status encoding used by the simulator FSM
//               and the VGA renderer that decodes sim_state.
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    localparam int NUM_FLOORS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2,
        DOORS = 2'd3
    } sim_state_t;

endpackage
`default_nettype wire

// File: rtl/elevator_sim_fsm_timer.sv
`default_nettype none
// ============================================================================
// Module      : floor_timer
// Description : Loadable down-counter; expired is high while enabled at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module floor_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expired = en && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/elevator_sim_fsm.sv
`default_nettype none
// ============================================================================
// Module      : elevator_sim_fsm
// Description : 8-floor SCAN elevator simulator; display outputs are shadowed
//               and refreshed only on frame_done so a frame never tears.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_sim_fsm
    import elevator_pkg::*;
#(
    parameter int FLOOR_TICKS = 12_000_000,
    parameter int DOOR_TICKS  = 24_000_000
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [NUM_FLOORS-1:0] req_btn,
    input  logic                  frame_done,
    output logic [1:0]            sim_state,
    output logic [NUM_FLOORS-1:0] destination,
    output logic [NUM_FLOORS-1:0] current_floor
);

    localparam int c_max_ticks = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int c_timer_w   = (c_max_ticks > 1) ? $clog2(c_max_ticks) : 1;
    localparam logic [c_timer_w-1:0]  c_floor_load = c_timer_w'(FLOOR_TICKS - 1);
    localparam logic [c_timer_w-1:0]  c_door_load  = c_timer_w'(DOOR_TICKS - 1);
    localparam logic [NUM_FLOORS-1:0] c_one        = NUM_FLOORS'(1);

    function automatic logic [NUM_FLOORS-1:0] lowest_bit(input logic [NUM_FLOORS-1:0] v);
        return v & (~v + c_one);
    endfunction

    function automatic logic [NUM_FLOORS-1:0] highest_bit(input logic [NUM_FLOORS-1:0] v);
        logic [NUM_FLOORS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (v[i]) r = c_one << i;
        end
        return r;
    endfunction

    sim_state_t            r_state, w_next_state, r_sim_state;
    logic [NUM_FLOORS-1:0] r_cur, w_next_floor;
    logic [NUM_FLOORS-1:0] r_pending, r_btn_q, r_dest;
    logic                  r_last_up, w_next_last_up;
    logic [NUM_FLOORS-1:0] w_rise, w_clr, w_target, w_step;
    logic [NUM_FLOORS-1:0] w_up_mask, w_dn_mask, w_near_up, w_near_dn;
    logic                  w_pend_here, w_any_up, w_any_dn, w_ahead, w_behind;
    logic                  w_tmr_load, w_tmr_en, w_tmr_exp;
    logic [c_timer_w-1:0]  w_tmr_val;

    assign w_rise      = req_btn & ~r_btn_q;
    assign w_up_mask   = ~(r_cur | (r_cur - c_one));
    assign w_dn_mask   = r_cur - c_one;
    assign w_pend_here = |(r_pending & r_cur);
    assign w_any_up    = |(r_pending & w_up_mask);
    assign w_any_dn    = |(r_pending & w_dn_mask);
    assign w_near_up   = lowest_bit(r_pending & w_up_mask);
    assign w_near_dn   = highest_bit(r_pending & w_dn_mask);
    assign w_ahead     = r_last_up ? w_any_up : w_any_dn;
    assign w_behind    = r_last_up ? w_any_dn : w_any_up;

    // One timer serves both travel and door phases; it is reloaded on every
    // entry into a timed phase, so its value is never carried across phases.
    assign w_tmr_en  = (r_state != IDLE);
    assign w_tmr_val = (w_next_state == DOORS) ? c_door_load : c_floor_load;

    floor_timer #(
        .WIDTH (c_timer_w)
    ) u_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .en       (w_tmr_en),
        .expired  (w_tmr_exp)
    );

    always_comb begin
        w_next_state   = r_state;
        w_next_floor   = r_cur;
        w_next_last_up = r_last_up;
        w_clr          = '0;
        w_tmr_load     = 1'b0;
        w_target       = '0;
        w_step         = '0;
        case (r_state)
            IDLE: begin
                if (w_pend_here) begin
                    w_next_state = DOORS;
                    w_clr        = r_cur;
                    w_tmr_load   = 1'b1;
                    w_target     = r_cur;
                end else if (w_any_up) begin
                    w_next_state   = UP;
                    w_next_last_up = 1'b1;
                    w_tmr_load     = 1'b1;
                    w_target       = w_near_up;
                end else if (w_any_dn) begin
                    w_next_state   = DOWN;
                    w_next_last_up = 1'b0;
                    w_tmr_load     = 1'b1;
                    w_target       = w_near_dn;
                end
            end
            UP, DOWN: begin
                w_target = (r_state == UP) ? w_near_up : w_near_dn;
                w_step   = (r_state == UP) ? (r_cur << 1) : (r_cur >> 1);
                if (w_tmr_exp) begin
                    // A step off either end shifts the one-hot to zero; stop rather than lose the car.
                    if (w_step == '0) begin
                        w_next_state = IDLE;
                    end else begin
                        w_next_floor = w_step;
                        w_tmr_load   = 1'b1;
                        if (|(r_pending & w_step)) begin
                            w_next_state = DOORS;
                            w_clr        = w_step;
                        end
                    end
                end
            end
            DOORS: begin
                if (w_ahead) begin
                    w_target = r_last_up ? w_near_up : w_near_dn;
                end else if (w_behind) begin
                    w_target = r_last_up ? w_near_dn : w_near_up;
                end
                if (w_pend_here) begin
                    w_clr      = r_cur;
                    w_tmr_load = 1'b1;
                end else if (w_tmr_exp) begin
                    w_tmr_load = 1'b1;
                    if (w_ahead) begin
                        w_next_state = r_last_up ? UP : DOWN;
                    end else if (w_behind) begin
                        w_next_state   = r_last_up ? DOWN : UP;
                        w_next_last_up = ~r_last_up;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_cur       <= c_one;
            r_pending   <= '0;
            r_btn_q     <= '0;
            r_last_up   <= 1'b1;
            r_sim_state <= IDLE;
            r_dest      <= '0;
        end else begin
            r_state   <= w_next_state;
            r_cur     <= w_next_floor;
            r_pending <= (r_pending | w_rise) & ~w_clr;
            r_btn_q   <= req_btn;
            r_last_up <= w_next_last_up;
            if (frame_done) begin
                r_sim_state <= r_state;
                r_dest      <= w_target;
            end
        end
    end

    assign sim_state     = r_sim_state;
    assign destination   = r_dest;
    assign current_floor = r_cur;

    a_no_up_at_top: assert property (@(posedge clk) disable iff (!n_rst)
        !((r_state == UP) && r_cur[NUM_FLOORS-1]));
    a_no_down_at_bottom: assert property (@(posedge clk) disable iff (!n_rst)
        !((r_state == DOWN) && r_cur[0]));

endmodule
`default_nettype wire

// File: tb/tb_elevator_sim_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_sim_fsm
// Description : Directed vector table plus hand sequences for elevator_sim_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_sim_fsm;
    import elevator_pkg::*;

    logic       clk     = 1'b0;
    logic       n_rst   = 1'b0;
    logic [7:0] req_btn = 8'h00;
    logic       frame_done;
    logic [1:0] sim_state;
    logic [7:0] destination;
    logic [7:0] current_floor;

    // 0: pulse every 10 cycles, 1: held high, 2: held low
    int fd_mode = 1;
    int fd_cnt  = 0;
    int checks  = 0;
    int errors  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) fd_cnt <= (fd_cnt == 9) ? 0 : fd_cnt + 1;
    assign frame_done = (fd_mode == 1) || ((fd_mode == 0) && (fd_cnt == 9));

    elevator_sim_fsm #(
        .FLOOR_TICKS (4),
        .DOOR_TICKS  (6)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .req_btn       (req_btn),
        .frame_done    (frame_done),
        .sim_state     (sim_state),
        .destination   (destination),
        .current_floor (current_floor)
    );

    typedef struct {
        logic [7:0] req;
        int         n;
        logic [7:0] cf;
        logic [1:0] st;
        logic [7:0] dst;
    } vec_t;

    vec_t vecs [22];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] cf, input logic [1:0] st,
                         input logic [7:0] dst);
        checks++;
        if (current_floor !== cf || sim_state !== st || destination !== dst) begin
            errors++;
            $display("FAIL %s: got floor=%h state=%0d dest=%h, want floor=%h state=%0d dest=%h",
                     name, current_floor, sim_state, destination, cf, st, dst);
        end
    endtask

    task automatic check_disp(input string name, input logic [1:0] st, input logic [7:0] dst);
        checks++;
        if (sim_state !== st || destination !== dst) begin
            errors++;
            $display("FAIL %s: got state=%0d dest=%h, want state=%0d dest=%h",
                     name, sim_state, destination, st, dst);
        end
    endtask

    initial begin
        // frame_done held high here: display shows the previous cycle's state/target
        vecs[0]  = '{8'h08,  1, 8'h01, IDLE,  8'h00};
        vecs[1]  = '{8'h08,  1, 8'h01, IDLE,  8'h08};
        vecs[2]  = '{8'h00,  1, 8'h01, UP,    8'h08};
        vecs[3]  = '{8'h00,  3, 8'h02, UP,    8'h08};
        vecs[4]  = '{8'h00,  4, 8'h04, UP,    8'h08};
        vecs[5]  = '{8'h00,  4, 8'h08, UP,    8'h08};
        vecs[6]  = '{8'h00,  1, 8'h08, DOORS, 8'h00};
        vecs[7]  = '{8'h00,  5, 8'h08, DOORS, 8'h00};
        vecs[8]  = '{8'h00,  1, 8'h08, IDLE,  8'h00};
        vecs[9]  = '{8'h80,  1, 8'h08, IDLE,  8'h00};
        vecs[10] = '{8'h00,  2, 8'h08, UP,    8'h80};
        vecs[11] = '{8'h01,  1, 8'h08, UP,    8'h80};
        vecs[12] = '{8'h00, 14, 8'h80, UP,    8'h80};
        vecs[13] = '{8'h00,  1, 8'h80, DOORS, 8'h01};
        vecs[14] = '{8'h00,  6, 8'h80, DOWN,  8'h01};
        vecs[15] = '{8'h00,  3, 8'h40, DOWN,  8'h01};
        vecs[16] = '{8'h00, 24, 8'h01, DOWN,  8'h01};
        vecs[17] = '{8'h00,  1, 8'h01, DOORS, 8'h00};
        vecs[18] = '{8'h00,  6, 8'h01, IDLE,  8'h00};
        vecs[19] = '{8'h01,  3, 8'h01, DOORS, 8'h00};
        vecs[20] = '{8'h01,  6, 8'h01, IDLE,  8'h00};
        vecs[21] = '{8'h01,  5, 8'h01, IDLE,  8'h00};

        tick(2);
        check("reset_state", 8'h01, IDLE, 8'h00);
        n_rst = 1'b1;
        tick(2);

        for (int k = 0; k < 22; k++) begin
            req_btn = vecs[k].req;
            tick(vecs[k].n);
            check($sformatf("vec%0d", k), vecs[k].cf, vecs[k].st, vecs[k].dst);
        end

        // Re-press floor 1 on its arrival cycle together with floor 5
        req_btn = 8'h02; tick(1);
        req_btn = 8'h00; tick(4);
        req_btn = 8'h22; tick(1);
        req_btn = 8'h00;
        check("arrive_f1", 8'h02, UP, 8'h02);
        tick(6);
        check("doors_f1_end", 8'h02, DOORS, 8'h20);
        tick(1);
        check("clear_wins", 8'h02, UP, 8'h20);
        tick(15);
        check("kept_f5", 8'h20, UP, 8'h20);
        tick(7);
        check("idle_f5", 8'h20, IDLE, 8'h00);

        // Current-floor press while doors open restarts the door timer
        req_btn = 8'h20; tick(1);
        req_btn = 8'h00; tick(3);
        req_btn = 8'h20; tick(1);
        req_btn = 8'h00; tick(5);
        check("door_restart", 8'h20, DOORS, 8'h00);
        tick(2);
        check("door_restart_end", 8'h20, DOORS, 8'h00);
        tick(1);
        check("door_restart_idle", 8'h20, IDLE, 8'h00);

        // Display frozen for 50 cycles while the car moves
        fd_mode = 2;
        for (int i = 1; i <= 50; i++) begin
            tick(1);
            check_disp($sformatf("frame_hold%0d", i), IDLE, 8'h00);
            if (i == 10) req_btn = 8'h81;
            if (i == 11) req_btn = 8'h00;
        end
        fd_mode = 1;
        tick(1);
        check("frame_update", 8'h02, DOWN, 8'h01);
        fd_mode = 2;
        tick(5);
        check("frame_hold_after", 8'h01, DOWN, 8'h01);
        tick(6);

        // Asynchronous reset in the middle of an upward move
        fd_mode = 0;
        req_btn = 8'h80; tick(1);
        req_btn = 8'h00; tick(13);
        check("pre_reset_up", 8'h08, UP, 8'h80);
        n_rst = 1'b0;
        #1;
        check("reset_async", 8'h01, IDLE, 8'h00);
        tick(3);
        n_rst = 1'b1;
        tick(20);
        check("post_reset_idle", 8'h01, IDLE, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
